// File: rtl/regfile_seq_ctrl_pkg.sv
// rtl/regfile_seq_ctrl_pkg.sv - shared states and button indices for regfile_seq_ctrl
package regfile_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam int BTN_ADDR  = 0;
  localparam int BTN_DATA  = 1;
  localparam int BTN_WRITE = 2;
  localparam int BTN_SCAN  = 3;
  localparam int BtnCount  = 4;

endpackage

// File: rtl/regfile_seq_ctrl_edge_rise.sv
// rtl/regfile_seq_ctrl_edge_rise.sv - synchronous rising-edge detector for level inputs
module edge_rise #(
  parameter int PortWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PortWidth-1:0] in,
  output logic [PortWidth-1:0] rise
);

  logic [PortWidth-1:0] in_q;

  // previous-cycle level; all-ones so a level held through reset gives no edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= '1;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - push-button sequencer for a single-port synchronous-read register file
module regfile_seq_ctrl
  import regfile_seq_ctrl_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 8,
  parameter int ScanDiv   = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           btn,
  output logic [AddrWidth-1:0] rf_addr,
  output logic [DataWidth-1:0] rf_wdata,
  output logic                 rf_we,
  input  logic [DataWidth-1:0] rf_rdata,
  output logic [15:0]          disp,
  output logic [3:0]           led,
  output logic                 busy
);

  localparam int CntWidth = $clog2(ScanDiv);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(ScanDiv - 1);

  state_t               state, state_d;
  logic [AddrWidth-1:0] addr, addr_d;
  logic [DataWidth-1:0] wdata, wdata_d;
  logic [DataWidth-1:0] shown_data, shown_d;
  logic                 pend_addr, pend_data, pend_write, pend_scan;
  logic                 clr_addr, clr_data, clr_write, clr_scan;
  logic                 scan_mode;
  logic [CntWidth-1:0]  scan_cnt;
  logic [BtnCount-1:0]  rise;

  edge_rise #(.PortWidth(BtnCount)) u_edge_rise (
    .clk  (clk),
    .reset(reset),
    .in   (btn),
    .rise (rise)
  );

  // next state: IDLE serves one pending flag per visit, write > addr > scan > data
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    wdata_d   = wdata;
    shown_d   = shown_data;
    clr_addr  = 1'b0;
    clr_data  = 1'b0;
    clr_write = 1'b0;
    clr_scan  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend_write) begin
          clr_write = 1'b1;
          state_d   = ST_WRITE;
        end else if (pend_addr) begin
          clr_addr = 1'b1;
          addr_d   = addr + AddrWidth'(1);
          state_d  = ST_READ;
        end else if (pend_scan) begin
          clr_scan = 1'b1;
          addr_d   = addr + AddrWidth'(1);
          state_d  = ST_READ;
        end else if (pend_data) begin
          clr_data = 1'b1;
          wdata_d  = wdata + DataWidth'(1);
        end
      end
      ST_WRITE:   state_d = ST_READ;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shown_d = rf_rdata;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and the address/data/display registers it owns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      wdata      <= '0;
      shown_data <= '0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
      shown_data <= shown_d;
    end
  end

  // button pending flags: a rise sets, servicing clears, a rise on the clear cycle wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_addr  <= 1'b0;
      pend_data  <= 1'b0;
      pend_write <= 1'b0;
    end else begin
      pend_addr  <= (pend_addr  & ~clr_addr)  | rise[BTN_ADDR];
      pend_data  <= (pend_data  & ~clr_data)  | rise[BTN_DATA];
      pend_write <= (pend_write & ~clr_write) | rise[BTN_WRITE];
    end
  end

  // scan mode toggle, step counter and scan pending flag, independent of the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_mode <= 1'b0;
      scan_cnt  <= '0;
      pend_scan <= 1'b0;
    end else if (rise[BTN_SCAN]) begin
      scan_mode <= ~scan_mode;
      scan_cnt  <= '0;
      pend_scan <= scan_mode ? 1'b0 : (pend_scan & ~clr_scan);
    end else if (scan_mode && scan_cnt == CntMax) begin
      scan_cnt  <= '0;
      pend_scan <= 1'b1;
    end else begin
      if (scan_mode) begin
        scan_cnt <= scan_cnt + CntWidth'(1);
      end
      pend_scan <= pend_scan & ~clr_scan;
    end
  end

  assign rf_addr  = addr;
  assign rf_wdata = wdata;
  assign rf_we    = (state == ST_WRITE);
  assign busy     = (state != ST_IDLE);
  assign led      = {scan_mode, busy, state};
  assign disp     = {8'(addr), 8'(shown_data)};

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - self-checking bench for regfile_seq_ctrl
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic [7:0]  rf_addr, rf_wdata, rf_rdata;
  logic        rf_we;
  logic [15:0] disp;
  logic [3:0]  led;
  logic        busy;

  int total = 0;
  int bad   = 0;

  regfile_seq_ctrl #(.AddrWidth(8), .DataWidth(8), .ScanDiv(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .rf_addr (rf_addr),
    .rf_wdata(rf_wdata),
    .rf_we   (rf_we),
    .rf_rdata(rf_rdata),
    .disp    (disp),
    .led     (led),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    logic [7:0] v;
    v = 8'(i);
    return v ^ 8'hA5;
  endfunction

  // register file environment: synchronous read, write on rf_we
  logic [7:0] rf_mem [256];
  logic       preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= pat(i);
      preloaded <= 1'b1;
    end else begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
      rf_rdata <= rf_mem[rf_addr];
    end
  end

  // write monitor
  int         we_total = 0;
  logic [7:0] last_we_addr = 8'h00;
  logic [7:0] last_we_data = 8'h00;
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      we_total     = we_total + 1;
      last_we_addr = rf_addr;
      last_we_data = rf_wdata;
    end
  end

  // behavioural reference: what each completed button press does
  logic [7:0] mem_model [256];
  logic [7:0] m_addr, m_wdata, m_shown;

  task automatic model_reset();
    m_addr = 8'h00; m_wdata = 8'h00; m_shown = 8'h00;
  endtask

  task automatic model_press(input int b);
    case (b)
      0: begin m_addr = m_addr + 8'd1; m_shown = mem_model[m_addr]; end
      1: m_wdata = m_wdata + 8'd1;
      2: begin mem_model[m_addr] = m_wdata; m_shown = m_wdata; end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // press from a negedge: hold 2 cycles, then 6 idle cycles so the access completes
  task automatic press(input logic [3:0] mask);
    btn = mask;
    @(negedge clk);
    @(negedge clk);
    btn = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    int          b;
    logic [15:0] exp_disp;
    int          exp_we;
    logic [7:0]  exp_waddr;
    logic [7:0]  exp_wdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int w0, b;
    logic [7:0] sa;

    tbl[0] = '{1, 16'h0000, 0, 8'h00, 8'h00};
    tbl[1] = '{1, 16'h0000, 0, 8'h00, 8'h00};
    tbl[2] = '{1, 16'h0000, 0, 8'h00, 8'h00};
    tbl[3] = '{2, 16'h0003, 1, 8'h00, 8'h03};
    tbl[4] = '{0, 16'h01A4, 0, 8'h00, 8'h00};
    tbl[5] = '{2, 16'h0103, 1, 8'h01, 8'h03};
    tbl[6] = '{0, 16'h02A7, 0, 8'h00, 8'h00};
    tbl[7] = '{1, 16'h02A7, 0, 8'h00, 8'h00};
    tbl[8] = '{2, 16'h0204, 1, 8'h02, 8'h04};

    for (int i = 0; i < 256; i++) mem_model[i] = pat(i);
    model_reset();

    btn   = 4'b0000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // idle after reset
    repeat (10) @(negedge clk);
    chk("rst_disp", disp, 16'h0000);
    chk("rst_led", led, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_no_we", we_total, 0);

    // directed table
    for (int i = 0; i < 9; i++) begin
      w0 = we_total;
      press(4'(1 << tbl[i].b));
      model_press(tbl[i].b);
      chk("tbl_disp", disp, tbl[i].exp_disp);
      chk("tbl_we_cnt", we_total - w0, tbl[i].exp_we);
      if (tbl[i].exp_we == 1) begin
        chk("tbl_we_addr", last_we_addr, tbl[i].exp_waddr);
        chk("tbl_we_data", last_we_data, tbl[i].exp_wdata);
      end
    end

    // cycle-exact write latency: edge k samples btn[2]
    press(4'b0010);
    model_press(1);
    btn = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    chk("lat_k_led", led, 4'b0000);
    @(negedge clk);
    btn = 4'b0000;
    chk("lat_k1_we", rf_we, 1'b1);
    chk("lat_k1_addr", rf_addr, 8'h02);
    chk("lat_k1_wdata", rf_wdata, 8'h05);
    chk("lat_k1_led", led, 4'b0101);
    @(negedge clk);
    chk("lat_k2_we", rf_we, 1'b0);
    chk("lat_k2_led", led, 4'b0110);
    @(negedge clk);
    chk("lat_k3_led", led, 4'b0111);
    chk("lat_k3_disp", disp, 16'h0204);
    @(negedge clk);
    chk("lat_k4_disp", disp, 16'h0205);
    chk("lat_k4_led", led, 4'b0000);
    model_press(2);
    repeat (3) @(negedge clk);

    // address wrap over 256 presses
    for (int i = 0; i < 256; i++) begin
      press(4'b0001);
      model_press(0);
      chk("wrap_disp", disp, {m_addr, m_shown});
    end
    chk("wrap_addr", disp[15:8], 8'h02);

    // random presses against the model
    for (int i = 0; i < 150; i++) begin
      b  = int'($urandom_range(0, 2));
      w0 = we_total;
      press(4'(1 << b));
      model_press(b);
      chk("rnd_disp", disp, {m_addr, m_shown});
      chk("rnd_we_cnt", we_total - w0, (b == 2) ? 1 : 0);
    end

    // write button held through reset release
    btn   = 4'b0100;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    w0 = we_total;
    repeat (10) @(negedge clk);
    chk("hold_no_we", we_total - w0, 0);
    chk("hold_busy", busy, 1'b0);
    chk("hold_disp", disp, 16'h0000);
    btn = 4'b0000;
    @(negedge clk);
    w0 = we_total;
    press(4'b0100);
    model_press(2);
    chk("hold_one_we", we_total - w0, 1);
    chk("hold_we_addr", last_we_addr, 8'h00);
    chk("hold_disp2", disp, {m_addr, m_shown});

    // simultaneous addr + write with wdata=5, addr=0x10
    for (int i = 0; i < 5; i++) begin press(4'b0010); model_press(1); end
    for (int i = 0; i < 16; i++) begin press(4'b0001); model_press(0); end
    chk("sim_pre_disp", disp, {8'h10, mem_model[8'h10]});
    w0 = we_total;
    press(4'b0101);
    model_press(2);
    model_press(0);
    chk("sim_we_cnt", we_total - w0, 1);
    chk("sim_we_addr", last_we_addr, 8'h10);
    chk("sim_we_data", last_we_data, 8'h05);
    chk("sim_disp", disp, {8'h11, mem_model[8'h11]});

    // auto-scan with ScanDiv=8: toggle at edge t0
    sa  = m_addr;
    btn = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    btn = 4'b0000;
    chk("scan_on_led", led[3], 1'b1);
    repeat (43) @(negedge clk);
    m_addr  = sa + 8'd5;
    m_shown = mem_model[m_addr];
    chk("scan_addr5", disp, {m_addr, m_shown});
    btn = 4'b1000;
    @(negedge clk);
    btn = 4'b0000;
    repeat (30) @(negedge clk);
    chk("scan_off_led", led[3], 1'b0);
    chk("scan_off_addr", disp, {m_addr, m_shown});

    // reset during WRITE
    btn = 4'b0100;
    @(negedge clk);
    btn = 4'b0000;
    for (int i = 0; i < 10 && rf_we !== 1'b1; i++) @(negedge clk);
    chk("rstw_seen_we", rf_we, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstw_we_drop", rf_we, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rstw_led", led, 4'b0000);
    chk("rstw_disp", disp, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
